// File: rtl/fifo_deq_unpacker_pkg.sv
// ---------------------------------------------------------------------------
// fifo_deq_unpacker_pkg
//   Shared helpers for the wide-to-narrow FIFO unpacker.
//   Holds only constant functions. They size the beat counter from the
//   elaboration-time parameters, and any other block can reuse them.
//   No ports (package).
// ---------------------------------------------------------------------------
package fifo_deq_unpacker_pkg;

  // Ceiling log2. clog2(1) is 0, clog2(4) is 2, clog2(5) is 3.
  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result++;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

  // A counter needs at least one bit, even when ratio is 1.
  function automatic int cntWidthOf(input int ratio);
    return (clog2(ratio) < 1) ? 1 : clog2(ratio);
  endfunction

endpackage

// File: rtl/fifo_deq_unpacker_unpack_slice_mux.sv
// ---------------------------------------------------------------------------
// unpack_slice_mux
//   Purely combinational beat selector. It picks slice number cnt_i out of
//   the held wide word. The beat order (LSB slice first or MSB slice first)
//   is fixed at elaboration time.
//   Ports:
//     word_i  [in_width-1:0]   held wide word
//     cnt_i   [cnt_width-1:0]  index of the beat to present
//     slice_o [out_width-1:0]  selected narrow beat
// ---------------------------------------------------------------------------
module unpack_slice_mux
  import fifo_deq_unpacker_pkg::*;
#(
  parameter int in_width  = 32,
  parameter int ratio     = 4,
  parameter bit lsb_first = 1'b1,
  localparam int out_width = in_width / ratio,
  localparam int cnt_width = cntWidthOf(ratio)
) (
  input  logic [in_width-1:0]  word_i,
  input  logic [cnt_width-1:0] cnt_i,
  output logic [out_width-1:0] slice_o
);

  int sliceIdx;

  // With MSB-first order, beat 0 is the top slice. The slice index is
  // therefore mirrored. The control logic keeps cnt_i at or below
  // ratio-1, so the part-select always stays inside the word.
  always_comb begin
    sliceIdx = lsb_first ? int'(cnt_i) : (ratio - 1 - int'(cnt_i));
    slice_o  = word_i[sliceIdx*out_width +: out_width];
  end

endmodule

// File: rtl/fifo_deq_unpacker.sv
// ---------------------------------------------------------------------------
// fifo_deq_unpacker
//   Reader-side engine. It dequeues one wide word from an upstream FIFO and
//   replays it as `ratio` narrow beats into a downstream FIFO. The final beat
//   of a word and the load of the next word can happen in the same cycle, so
//   a steady stream runs at one beat per cycle with no bubbles.
//   Ports:
//     CLK         clock, all state changes on the rising edge
//     RST         synchronous active-high reset
//     CLR         synchronous flush of the held word
//     IN_EMPTY_N  upstream FIFO has data
//     IN_D        upstream FIFO head word
//     IN_DEQ      dequeue strobe to upstream
//     OUT_FULL_N  downstream FIFO has space
//     OUT_D       current narrow beat
//     OUT_ENQ     enqueue strobe to downstream
//     OUT_LAST    current beat is the last beat of its word
//     BUSY        a word is held
// ---------------------------------------------------------------------------
module fifo_deq_unpacker
  import fifo_deq_unpacker_pkg::*;
#(
  parameter int in_width  = 32,
  parameter int ratio     = 4,
  parameter bit lsb_first = 1'b1,
  localparam int out_width = in_width / ratio,
  localparam int cnt_width = cntWidthOf(ratio)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 CLR,
  input  logic                 IN_EMPTY_N,
  input  logic [in_width-1:0]  IN_D,
  output logic                 IN_DEQ,
  input  logic                 OUT_FULL_N,
  output logic [out_width-1:0] OUT_D,
  output logic                 OUT_ENQ,
  output logic                 OUT_LAST,
  output logic                 BUSY
);

  localparam logic [cnt_width-1:0] LastIdx = cnt_width'(ratio - 1);

  logic                 valid_q, valid_d;
  logic [cnt_width-1:0] cnt_q, cnt_d;
  logic [in_width-1:0]  heldWord_q, heldWord_d;
  logic                 lastBeat;

  // Handshake strobes. Reset and flush both block traffic in the same cycle.
  // A new word can be taken when nothing is held. It can also be taken when
  // the held word's final beat leaves this cycle, which gives the
  // no-bubble hand-over between words.
  always_comb begin
    lastBeat = (cnt_q == LastIdx);
    OUT_ENQ  = !RST && !CLR && valid_q && OUT_FULL_N;
    IN_DEQ   = !RST && !CLR && IN_EMPTY_N && (!valid_q || (OUT_ENQ && lastBeat));
    OUT_LAST = valid_q && lastBeat;
    BUSY     = valid_q;
  end

  // Next-state selection. A flush wins over everything else. Loading a
  // word takes priority over retiring the final beat, because the two
  // coincide on a hand-over. The counter stops at the last beat and
  // never wraps on its own.
  always_comb begin
    valid_d    = valid_q;
    cnt_d      = cnt_q;
    heldWord_d = heldWord_q;
    if (CLR) begin
      valid_d = 1'b0;
      cnt_d   = '0;
    end else if (IN_DEQ) begin
      heldWord_d = IN_D;
      valid_d    = 1'b1;
      cnt_d      = '0;
    end else if (OUT_ENQ && lastBeat) begin
      valid_d = 1'b0;
      cnt_d   = '0;
    end else if (OUT_ENQ) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State registers with synchronous reset. Clearing the held word on
  // reset makes OUT_D read as zero until the first load.
  always_ff @(posedge CLK) begin
    if (RST) begin
      valid_q    <= 1'b0;
      cnt_q      <= '0;
      heldWord_q <= '0;
    end else begin
      valid_q    <= valid_d;
      cnt_q      <= cnt_d;
      heldWord_q <= heldWord_d;
    end
  end

  unpack_slice_mux #(
    .in_width (in_width),
    .ratio    (ratio),
    .lsb_first(lsb_first)
  ) uSliceMux (
    .word_i (heldWord_q),
    .cnt_i  (cnt_q),
    .slice_o(OUT_D)
  );

  // A dequeue from an empty upstream FIFO would be a control bug.
  assert property (@(posedge CLK) IN_DEQ |-> IN_EMPTY_N)
    else $warning("fifo_deq_unpacker: IN_DEQ asserted while IN_EMPTY_N is low");

endmodule

// File: tb/tb_fifo_deq_unpacker.sv
// ---------------------------------------------------------------------------
// tb_fifo_deq_unpacker
//   Drives three unpacker configurations from one shared stream of source
//   words:
//     lane 0: 32-bit word, 4 beats, LSB slice first
//     lane 1: 32-bit word, 4 beats, MSB slice first
//     lane 2:  8-bit word, 1 beat
//   Each lane keeps a reference model. The model is a queue of the beats
//   still owed for the held word, plus a read pointer into the source list.
//   The lane compares every DUT output against that model on each falling
//   edge.
// ---------------------------------------------------------------------------
module tb_fifo_deq_unpacker;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic clr   = 1'b0;
  logic fullN = 1'b1;
  bit   gateAll = 1'b1;

  logic [31:0] wordList[$];

  int checkCount = 0;
  int failCount  = 0;

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h at %0t",
               tag, observed, expected, $time);
    end
  endtask

  // Beat k of a word, taken with plain shift-and-mask arithmetic.
  function automatic logic [31:0] beatOf(input logic [31:0] word, input int k,
                                         input int iw, input int rt, input bit lsb);
    int          ow;
    int          idx;
    logic [63:0] w;
    ow  = iw / rt;
    idx = lsb ? k : (rt - 1 - k);
    w   = {32'd0, word};
    return 32'((w >> (idx * ow)) & ((64'd1 << ow) - 64'd1));
  endfunction

  for (genvar g = 0; g < 3; g++) begin : gLane
    localparam int IW  = (g == 2) ? 8 : 32;
    localparam int RT  = (g == 2) ? 1 : 4;
    localparam bit LSB = (g != 1);
    localparam int OW  = IW / RT;

    logic          inEmptyN = 1'b0;
    logic [IW-1:0] inD      = '0;
    logic          inDeq;
    logic [OW-1:0] outD;
    logic          outEnq;
    logic          outLast;
    logic          busy;

    int          rdPtr    = 0;
    logic [31:0] beatQ[$];
    bit          idleZero = 1'b0;
    bit          expDeq   = 1'b0;
    bit          expEnq   = 1'b0;

    fifo_deq_unpacker #(
      .in_width (IW),
      .ratio    (RT),
      .lsb_first(LSB)
    ) dut (
      .CLK       (clk),
      .RST       (rst),
      .CLR       (clr),
      .IN_EMPTY_N(inEmptyN),
      .IN_D      (inD),
      .IN_DEQ    (inDeq),
      .OUT_FULL_N(fullN),
      .OUT_D     (outD),
      .OUT_ENQ   (outEnq),
      .OUT_LAST  (outLast),
      .BUSY      (busy)
    );

    // Advance the model on the clock edge, then offer the next source word.
    always @(posedge clk) begin
      if (rst) begin
        beatQ.delete();
        idleZero = 1'b1;
      end else if (clr) begin
        beatQ.delete();
      end else if (expDeq) begin
        beatQ.delete();
        for (int k = 0; k < RT; k++)
          beatQ.push_back(beatOf(wordList[rdPtr], k, IW, RT, LSB));
        rdPtr++;
        idleZero = 1'b0;
      end else if (expEnq) begin
        void'(beatQ.pop_front());
      end
      #2;
      inEmptyN = (rdPtr < wordList.size()) && (gateAll || ($urandom_range(0, 3) != 0));
      inD      = inEmptyN ? IW'(wordList[rdPtr]) : IW'($urandom);
    end

    // Expected strobes come straight from the handshake rules. The beat
    // data, last flag and busy flag come from what the model still owes.
    always @(negedge clk) begin
      int n;
      n      = beatQ.size();
      expEnq = !rst && !clr && (n > 0) && fullN;
      expDeq = !rst && !clr && inEmptyN && ((n == 0) || (expEnq && (n == 1)));
      checkOutput($sformatf("L%0d.deq", g), 32'(inDeq), 32'(expDeq));
      checkOutput($sformatf("L%0d.enq", g), 32'(outEnq), 32'(expEnq));
      checkOutput($sformatf("L%0d.busy", g), 32'(busy), 32'(n > 0));
      checkOutput($sformatf("L%0d.last", g), 32'(outLast), 32'(n == 1));
      if (n > 0)
        checkOutput($sformatf("L%0d.data", g), 32'(outD), beatQ[0]);
      else if (idleZero)
        checkOutput($sformatf("L%0d.idleData", g), 32'(outD), 32'd0);
    end
  end

  task automatic applyStimulus(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  initial begin
    $display("[TB] start");
    // Reset for two cycles, then a single word.
    applyStimulus(2);
    rst = 1'b0;
    wordList.push_back(32'hDDCCBBAA);
    applyStimulus(8);

    // Two queued words that must stream with no gap.
    wordList.push_back(32'h03020100);
    wordList.push_back(32'h07060504);
    applyStimulus(12);

    // Backpressure for three cycles after beat BB.
    wordList.push_back(32'hDDCCBBAA);
    applyStimulus(3);
    fullN = 1'b0;
    applyStimulus(3);
    fullN = 1'b1;
    applyStimulus(8);

    // Flush after beat BB while the next word is waiting.
    wordList.push_back(32'hDDCCBBAA);
    wordList.push_back(32'h44332211);
    applyStimulus(3);
    clr = 1'b1;
    applyStimulus(1);
    clr = 1'b0;
    applyStimulus(8);

    // Reset mid-word after beat AA, then a fresh word.
    wordList.push_back(32'hDDCCBBAA);
    applyStimulus(2);
    rst = 1'b1;
    applyStimulus(1);
    rst = 1'b0;
    wordList.push_back(32'h5A5AA5A5);
    applyStimulus(8);

    // Randomized traffic: sparse upstream, random backpressure,
    // occasional flush and reset.
    gateAll = 1'b0;
    for (int c = 0; c < 800; c++) begin
      fullN = ($urandom_range(0, 3) != 0);
      clr   = ($urandom_range(0, 49) == 0);
      rst   = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 99) < 18)
        wordList.push_back($urandom);
      applyStimulus(1);
    end
    clr   = 1'b0;
    rst   = 1'b0;
    fullN = 1'b1;
    applyStimulus(20);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
